// File: rtl/cache_perf_pkg.sv
// Shared encodings and record types for the cache hit/miss performance counters.
package cache_perf_pkg;

    localparam logic [2:0] SEL_RH  = 3'd0;
    localparam logic [2:0] SEL_WH  = 3'd1;
    localparam logic [2:0] SEL_RM  = 3'd2;
    localparam logic [2:0] SEL_WM  = 3'd3;
    localparam logic [2:0] SEL_CYC = 3'd4;
    localparam logic [2:0] SEL_OVF = 3'd5;

    localparam int unsigned NUM_KIND = 4;

    // Field order puts rh at bit 0 so a packed view indexes with SEL_RH..SEL_WM.
    typedef struct packed {
        logic wm;
        logic rm;
        logic wh;
        logic rh;
    } ch_evt_t;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating event counter with sticky overflow flag; clear wins over increment.
module perf_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (inc) begin
            if (count_q == '1) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/cache_perf_counter.sv
// Per-channel cache read/write hit/miss counters with a global cycle counter,
// a snapshot shadow bank and a registered readout port.
module cache_perf_counter
    import cache_perf_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [NUM_CH-1:0] ch_read,
    input  logic [NUM_CH-1:0] ch_write,
    input  logic [NUM_CH-1:0] ch_stall,
    input  logic              snap,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic              any_ovf
);

    logic [NUM_CH-1:0]   prev_stall_q, prev_stall_d;
    logic [NUM_CH-1:0]   pend_q, pend_d;
    logic [NUM_CH-1:0]   miss_start;
    logic [NUM_CH-1:0]   hit;
    logic [NUM_KIND-1:0] inc_vec [NUM_CH];

    logic [CNT_W-1:0]    live_cnt [NUM_CH][NUM_KIND];
    logic [NUM_KIND-1:0] live_ovf [NUM_CH];
    logic [NUM_CH-1:0]   ch_ovf;
    logic [CNT_W-1:0]    cyc_cnt;
    logic                cyc_ovf;

    logic [CNT_W-1:0]    shd_cnt_q [NUM_CH][NUM_KIND];
    logic [CNT_W-1:0]    shd_cnt_d [NUM_CH][NUM_KIND];
    logic [NUM_CH-1:0]   shd_ovf_q, shd_ovf_d;
    logic [CNT_W-1:0]    shd_cyc_q, shd_cyc_d;
    logic                shd_ovf_cyc_q, shd_ovf_cyc_d;

    logic [CNT_W-1:0]    rd_data_q, rd_data_d;
    logic                any_ovf_q, any_ovf_d;
    logic                ch_ok;
    logic [CH_W-1:0]     ch_idx;

    // A miss is recognised only on the stall rising edge; the stall-release
    // cycle that retires a pending miss is not a hit.
    always_comb begin
        ch_evt_t ev;
        miss_start   = ch_stall & ~prev_stall_q;
        hit          = ~ch_stall & ~pend_q;
        prev_stall_d = ch_stall;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            ev.rh      = en & hit[c] & ch_read[c];
            ev.wh      = en & hit[c] & ch_write[c];
            ev.rm      = en & miss_start[c] & ch_read[c];
            ev.wm      = en & miss_start[c] & ch_write[c];
            inc_vec[c] = ev;
        end
        if (clr) begin
            pend_d = '0;
        end else if (en) begin
            pend_d = miss_start | (pend_q & ch_stall);
        end else begin
            pend_d = pend_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_stall_q <= '0;
            pend_q       <= '0;
        end else begin
            prev_stall_q <= prev_stall_d;
            pend_q       <= pend_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        for (genvar k = 0; k < NUM_KIND; k++) begin : g_kind
            perf_sat_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (inc_vec[c][k]),
                .clr   (clr),
                .count (live_cnt[c][k]),
                .ovf   (live_ovf[c][k])
            );
        end
    end

    perf_sat_counter #(.CNT_W(CNT_W)) u_cyc (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (en),
        .clr   (clr),
        .count (cyc_cnt),
        .ovf   (cyc_ovf)
    );

    // Shadow captures the registered live values, i.e. the state before this
    // edge's increment or clear.
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            ch_ovf[c] = |live_ovf[c];
        end
        shd_cnt_d     = shd_cnt_q;
        shd_ovf_d     = shd_ovf_q;
        shd_cyc_d     = shd_cyc_q;
        shd_ovf_cyc_d = shd_ovf_cyc_q;
        if (snap) begin
            shd_cnt_d     = live_cnt;
            shd_ovf_d     = ch_ovf;
            shd_cyc_d     = cyc_cnt;
            shd_ovf_cyc_d = cyc_ovf;
        end
    end

    always_comb begin
        ch_ok     = (32'(rd_ch) < NUM_CH);
        ch_idx    = ch_ok ? rd_ch : '0;
        rd_data_d = '0;
        case (rd_sel)
            SEL_RH, SEL_WH, SEL_RM, SEL_WM: begin
                if (ch_ok) begin
                    rd_data_d = shd_cnt_q[ch_idx][rd_sel[1:0]];
                end
            end
            SEL_CYC: rd_data_d = shd_cyc_q;
            SEL_OVF: begin
                if (ch_ok) begin
                    rd_data_d[1:0] = {shd_ovf_cyc_q, shd_ovf_q[ch_idx]};
                end
            end
            default: rd_data_d = '0;
        endcase
        any_ovf_d = cyc_ovf | (|ch_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                for (int unsigned k = 0; k < NUM_KIND; k++) begin
                    shd_cnt_q[c][k] <= '0;
                end
            end
            shd_ovf_q     <= '0;
            shd_cyc_q     <= '0;
            shd_ovf_cyc_q <= 1'b0;
            rd_data_q     <= '0;
            any_ovf_q     <= 1'b0;
        end else begin
            shd_cnt_q     <= shd_cnt_d;
            shd_ovf_q     <= shd_ovf_d;
            shd_cyc_q     <= shd_cyc_d;
            shd_ovf_cyc_q <= shd_ovf_cyc_d;
            rd_data_q     <= rd_data_d;
            any_ovf_q     <= any_ovf_d;
        end
    end

    assign rd_data = rd_data_q;
    assign any_ovf = any_ovf_q;

endmodule

// File: tb/tb_cache_perf_counter.sv
// Self-checking bench for cache_perf_counter: vector table, directed corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_cache_perf_counter;

    localparam int NCH  = 5;
    localparam int CW   = 8;
    localparam int CHW  = 3;
    localparam int MAXV = 255;

    logic           clk = 1'b0;
    logic           rst_n, en, clr, snap;
    logic [NCH-1:0] ch_read, ch_write, ch_stall;
    logic [CHW-1:0] rd_ch;
    logic [2:0]     rd_sel;
    logic [CW-1:0]  rd_data;
    logic           any_ovf;

    int total = 0;
    int bad   = 0;

    cache_perf_counter #(.NUM_CH(NCH), .CNT_W(CW), .CH_W(CHW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .ch_read  (ch_read),
        .ch_write (ch_write),
        .ch_stall (ch_stall),
        .snap     (snap),
        .rd_ch    (rd_ch),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .any_ovf  (any_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // Reference model: counter index 0=RH 1=WH 2=RM 3=WM.
    int m_cnt [NCH][4];
    bit m_ovf [NCH];
    bit m_pend[NCH];
    bit m_prev[NCH];
    int m_cyc;
    bit m_ovf_cyc;
    int s_cnt [NCH][4];
    bit s_ovf [NCH];
    int s_cyc;
    bit s_ovf_cyc;
    int m_rd;
    bit m_any;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < 4; k++) begin
                m_cnt[c][k] = 0;
                s_cnt[c][k] = 0;
            end
            m_ovf[c] = 0; m_pend[c] = 0; m_prev[c] = 0; s_ovf[c] = 0;
        end
        m_cyc = 0; m_ovf_cyc = 0; s_cyc = 0; s_ovf_cyc = 0;
        m_rd = 0; m_any = 0;
    endfunction

    function automatic void bump(input int c, input int k);
        if (m_cnt[c][k] == MAXV) m_ovf[c] = 1;
        else m_cnt[c][k] = m_cnt[c][k] + 1;
    endfunction

    function automatic void model_edge();
        int sel = int'(rd_sel);
        int ch  = int'(rd_ch);
        int nrd = 0;
        bit nany = m_ovf_cyc;
        if (sel == 4) nrd = s_cyc;
        else if (ch < NCH && sel < 4) nrd = s_cnt[ch][sel];
        else if (ch < NCH && sel == 5) nrd = (s_ovf_cyc ? 2 : 0) + (s_ovf[ch] ? 1 : 0);
        for (int c = 0; c < NCH; c++) nany = nany | m_ovf[c];
        if (snap) begin
            s_cnt = m_cnt; s_ovf = m_ovf; s_cyc = m_cyc; s_ovf_cyc = m_ovf_cyc;
        end
        if (clr) begin
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < 4; k++) m_cnt[c][k] = 0;
                m_ovf[c] = 0; m_pend[c] = 0;
            end
            m_cyc = 0; m_ovf_cyc = 0;
        end else if (en) begin
            for (int c = 0; c < NCH; c++) begin
                if (ch_stall[c] && !m_prev[c]) begin
                    m_pend[c] = 1;
                    if (ch_read[c])  bump(c, 2);
                    if (ch_write[c]) bump(c, 3);
                end else if (!ch_stall[c] && m_pend[c]) begin
                    m_pend[c] = 0;
                end else if (!ch_stall[c]) begin
                    if (ch_read[c])  bump(c, 0);
                    if (ch_write[c]) bump(c, 1);
                end
            end
            if (m_cyc == MAXV) m_ovf_cyc = 1;
            else m_cyc = m_cyc + 1;
        end
        for (int c = 0; c < NCH; c++) m_prev[c] = ch_stall[c];
        m_rd  = nrd;
        m_any = nany;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        if (rst_n) model_edge();
        @(posedge clk);
        #1;
        chk("model_rd_data", rd_data, m_rd);
        chk("model_any_ovf", any_ovf, m_any);
    endtask

    task automatic idle();
        ch_read = '0; ch_write = '0; ch_stall = '0; snap = 0; clr = 0;
    endtask

    task automatic do_snap();
        snap = 1; tick(); snap = 0;
    endtask

    task automatic rd_check(input int ch, input int sel, input int exp, input string nm);
        rd_ch = CHW'(ch); rd_sel = 3'(sel);
        tick();
        chk(nm, rd_data, exp);
    endtask

    typedef struct {
        logic [NCH-1:0] rd, wr, st;
        logic           en, snap;
        logic [CHW-1:0] rch;
        logic [2:0]     sel;
        int             exp_rd;
        logic           exp_any;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [NCH-1:0] rd, input logic [NCH-1:0] wr,
                                input logic [NCH-1:0] st, input logic sn,
                                input int rch, input int sel, input int exp_rd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.st = st; v.en = 1'b1; v.snap = sn;
        v.rch = CHW'(rch); v.sel = 3'(sel); v.exp_rd = exp_rd; v.exp_any = 1'b0;
        return v;
    endfunction

    initial begin
        rst_n = 0; en = 0; rd_ch = '0; rd_sel = '0;
        idle();
        model_reset();

        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 1, 0, 0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(5'b00001, 5'b00000, 5'b00000, 0, 0, 0, 0));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 1, 0, 0, 0));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 5));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 0, 0, 2, 0));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 0, 0, 4, 6));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(5'b00000, 5'b00100, 5'b00100, 0, 0, 4, 6));
        tbl.push_back(mk(5'b00000, 5'b00100, 5'b00000, 0, 0, 4, 6));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 1, 0, 4, 6));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 0, 2, 3, 1));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 0, 2, 1, 0));
        tbl.push_back(mk(5'b00000, 5'b00100, 5'b00000, 0, 2, 3, 1));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 1, 2, 1, 0));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 0, 2, 1, 1));
        tbl.push_back(mk(5'b00010, 5'b00010, 5'b00000, 0, 1, 0, 0));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 1, 1, 0, 0));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 0, 1, 0, 1));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 0, 1, 1, 1));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 0, 1, 2, 0));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 0, 2, 2, 0));

        repeat (2) tick();
        chk("reset_rd_data", rd_data, 0);
        chk("reset_any_ovf", any_ovf, 0);
        rst_n = 1;

        foreach (tbl[i]) begin
            ch_read = tbl[i].rd; ch_write = tbl[i].wr; ch_stall = tbl[i].st;
            en = tbl[i].en; snap = tbl[i].snap; rd_ch = tbl[i].rch; rd_sel = tbl[i].sel;
            tick();
            chk("tbl_rd_data", rd_data, tbl[i].exp_rd);
            chk("tbl_any_ovf", any_ovf, int'(tbl[i].exp_any));
        end
        idle();

        // Enable raised in mid-stall must not register a miss.
        en = 0; ch_stall[1] = 1; ch_read[1] = 1;
        repeat (2) tick();
        en = 1;
        repeat (3) tick();
        idle();
        tick();
        do_snap();
        rd_check(1, 2, 0, "en_midstall_rm1");
        rd_check(1, 0, 1, "en_midstall_rh1");

        // Saturation: CYC also passes 255 over these 300 enabled cycles.
        clr = 1; tick(); clr = 0;
        ch_read[3] = 1;
        repeat (300) tick();
        idle();
        tick();
        chk("sat_any_ovf", any_ovf, 1);
        do_snap();
        rd_check(3, 0, 255, "sat_rh3");
        rd_check(3, 5, 3, "sat_ovf3");
        rd_check(2, 5, 2, "sat_ovf2");
        clr = 1; tick(); clr = 0;
        chk("clr_any_ovf_1cyc", any_ovf, 1);
        tick();
        chk("clr_any_ovf_2cyc", any_ovf, 0);
        do_snap();
        rd_check(3, 0, 0, "clr_rh3");
        rd_check(3, 5, 0, "clr_ovf3");

        // Clear and snapshot in the same cycle.
        ch_read[0] = 1;
        repeat (7) tick();
        idle();
        clr = 1; snap = 1; tick(); clr = 0; snap = 0;
        rd_check(0, 0, 7, "clrsnap_shadow_rh0");
        rd_check(NCH, 0, 0, "rd_ch_out_of_range");
        do_snap();
        rd_check(0, 0, 0, "clrsnap_live_rh0");
        rd_sel = 3'(4);
        tick();

        // Asynchronous reset in the middle of a miss.
        ch_stall[1] = 1; ch_read[1] = 1;
        repeat (3) tick();
        #2 rst_n = 0;
        #1;
        chk("async_rst_rd_data", rd_data, 0);
        chk("async_rst_any_ovf", any_ovf, 0);
        model_reset();
        idle();
        @(posedge clk);
        #1 rst_n = 1;
        ch_read[1] = 1;
        tick();
        idle();
        do_snap();
        rd_check(1, 0, 1, "post_rst_rh1");
        rd_check(1, 2, 0, "post_rst_rm1");

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            en    = ($urandom_range(0, 9) != 0);
            clr   = ($urandom_range(0, 59) == 0);
            snap  = ($urandom_range(0, 7) == 0);
            rd_ch = CHW'($urandom_range(0, 7));
            rd_sel = 3'($urandom_range(0, 7));
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 3) == 0) ch_stall[c] = ~ch_stall[c];
                ch_read[c]  = $urandom_range(0, 1) != 0;
                ch_write[c] = $urandom_range(0, 2) == 0;
            end
            tick();
        end
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
